// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants, encodings and decode helpers for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int XLEN  = 64;
    localparam int ACC_W = 2 * XLEN;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } step_mode_t;

    function automatic logic op_signed_rs1(input logic [2:0] f3);
        return (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
               (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

    function automatic logic op_signed_rs2(input logic [2:0] f3);
        return (f3 == FUNCT3_MUL) || (f3 == FUNCT3_MULH) ||
               (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module      : muldiv_unit_if
// Description : Issue/writeback bundle between the execute stage and muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if;
    import cpu_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic            is_word;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_address_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_address_out;
    logic            reg_write;

    modport master (
        output start, funct3, is_word, rs1_data, rs2_data, rd_address_in,
        input  busy, done, result, rd_address_out, reg_write
    );

    modport slave (
        input  start, funct3, is_word, rs1_data, rs2_data, rd_address_in,
        output busy, done, result, rd_address_out, reg_write
    );

endinterface

`default_nettype wire

// File: rtl/muldiv_unit_step.sv
// ============================================================================
// Module      : muldiv_step
// Description : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step
    import cpu_pkg::*;
(
    input  wire logic [ACC_W-1:0] i_acc,
    input  wire logic [XLEN-1:0]  i_operand,
    input  step_mode_t            i_mode,
    output logic      [ACC_W-1:0] o_acc_next
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_hi_keep;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    always_comb begin
        w_sum     = {1'b0, i_acc[ACC_W-1:XLEN]} + {1'b0, i_operand};
        w_hi_keep = {1'b0, i_acc[ACC_W-1:XLEN]};
        // Remainder shifted left with the next dividend bit pulled in from the low half
        w_trial   = {i_acc[ACC_W-1:XLEN], i_acc[XLEN-1]};
        w_ge      = (w_trial >= {1'b0, i_operand});
        w_diff    = w_trial[XLEN-1:0] - i_operand;
        if (i_mode == MODE_MUL) begin
            o_acc_next = {(i_acc[0] ? w_sum : w_hi_keep), i_acc[XLEN-1:1]};
        end else begin
            o_acc_next = {(w_ge ? w_diff : w_trial[XLEN-1:0]), i_acc[XLEN-2:0], w_ge};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV64M multiply/divide unit, one radix-2 step per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
    import cpu_pkg::*;
(
    input  wire logic    clock,
    input  wire logic    reset_n,
    muldiv_unit_if.slave bus
);

    localparam logic [XLEN-1:0] c_dword_min = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] c_word_min  = 64'hFFFF_FFFF_8000_0000;

    state_t           r_state;
    logic [5:0]       r_count;
    logic [2:0]       r_funct3;
    logic             r_is_word;
    logic [4:0]       r_rd;
    logic [ACC_W-1:0] r_acc;
    logic [XLEN-1:0]  r_opb;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_special;
    logic             r_done;
    logic             r_reg_write;
    logic [XLEN-1:0]  r_result;
    logic [4:0]       r_rd_out;

    logic             w_signed_a, w_signed_b, w_sa, w_sb;
    logic [XLEN-1:0]  w_a_ext, w_b_ext, w_mag_a, w_mag_b, w_min;
    logic             w_is_div, w_div_zero, w_overflow, w_invalid, w_special;
    logic [XLEN-1:0]  w_special_result;
    logic [ACC_W-1:0] w_acc_init;
    logic [ACC_W-1:0] w_step_next;
    logic [ACC_W-1:0] w_prod_mag, w_prod;
    logic [XLEN-1:0]  w_mul_res, w_quot, w_rem, w_div_res, w_raw, w_final;
    logic [5:0]       w_last;

    always_comb begin
        w_signed_a = op_signed_rs1(bus.funct3);
        w_signed_b = op_signed_rs2(bus.funct3);
        if (bus.is_word) begin
            w_a_ext = w_signed_a ? {{32{bus.rs1_data[31]}}, bus.rs1_data[31:0]}
                                 : {32'b0, bus.rs1_data[31:0]};
            w_b_ext = w_signed_b ? {{32{bus.rs2_data[31]}}, bus.rs2_data[31:0]}
                                 : {32'b0, bus.rs2_data[31:0]};
        end else begin
            w_a_ext = bus.rs1_data;
            w_b_ext = bus.rs2_data;
        end
        w_sa       = w_signed_a & w_a_ext[XLEN-1];
        w_sb       = w_signed_b & w_b_ext[XLEN-1];
        w_mag_a    = w_sa ? -w_a_ext : w_a_ext;
        w_mag_b    = w_sb ? -w_b_ext : w_b_ext;
        w_is_div   = bus.funct3[2];
        w_min      = bus.is_word ? c_word_min : c_dword_min;
        w_div_zero = w_is_div && (w_b_ext == '0);
        w_overflow = w_is_div && !bus.funct3[0] && (w_a_ext == w_min) && (w_b_ext == '1);
        w_invalid  = bus.is_word && !w_is_div && (bus.funct3[1:0] != 2'b00);
        w_special  = w_div_zero || w_overflow || w_invalid;

        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = bus.funct3[1] ? w_a_ext : '1;
        end else if (w_overflow) begin
            w_special_result = bus.funct3[1] ? '0 : w_a_ext;
        end

        // Word divides park the 32-bit dividend in the top of the low half so
        // that 32 iterations consume exactly its bits.
        if (w_is_div && bus.is_word) begin
            w_acc_init = {{XLEN{1'b0}}, w_mag_a[31:0], 32'b0};
        end else begin
            w_acc_init = {{XLEN{1'b0}}, w_mag_a};
        end
    end

    muldiv_step u_step (
        .i_acc      (r_acc),
        .i_operand  (r_opb),
        .i_mode     (r_funct3[2] ? MODE_DIV : MODE_MUL),
        .o_acc_next (w_step_next)
    );

    always_comb begin
        // After 32 shifts a word product sits 32 bits up in the accumulator
        w_prod_mag = r_is_word ? {{XLEN{1'b0}}, r_acc[95:32]} : r_acc;
        w_prod     = r_neg_q ? -w_prod_mag : w_prod_mag;
        w_mul_res  = (r_funct3 == FUNCT3_MUL) ? w_prod[XLEN-1:0] : w_prod[ACC_W-1:XLEN];
        w_quot     = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem      = r_neg_r ? -r_acc[ACC_W-1:XLEN] : r_acc[ACC_W-1:XLEN];
        w_div_res  = r_funct3[1] ? w_rem : w_quot;
        w_raw      = r_special ? r_acc[XLEN-1:0] : (r_funct3[2] ? w_div_res : w_mul_res);
        w_final    = r_is_word ? {{32{w_raw[31]}}, w_raw[31:0]} : w_raw;
        w_last     = r_is_word ? 6'd31 : 6'd63;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_funct3    <= '0;
            r_is_word   <= 1'b0;
            r_rd        <= '0;
            r_acc       <= '0;
            r_opb       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_special   <= 1'b0;
            r_done      <= 1'b0;
            r_reg_write <= 1'b0;
            r_result    <= '0;
            r_rd_out    <= '0;
        end else begin
            r_done      <= 1'b0;
            r_reg_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_funct3  <= bus.funct3;
                        r_is_word <= bus.is_word;
                        r_rd      <= bus.rd_address_in;
                        r_opb     <= w_mag_b;
                        r_neg_q   <= w_sa ^ w_sb;
                        r_neg_r   <= w_sa;
                        r_count   <= '0;
                        r_special <= w_special;
                        r_acc     <= w_special ? {{XLEN{1'b0}}, w_special_result} : w_acc_init;
                        r_state   <= w_special ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_step_next;
                    r_count <= r_count + 6'd1;
                    if (r_count == w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done      <= 1'b1;
                    r_reg_write <= (r_rd != 5'd0);
                    r_result    <= w_final;
                    r_rd_out    <= r_rd;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.done           = r_done;
    assign bus.reg_write      = r_reg_write;
    assign bus.result         = r_result;
    assign bus.rd_address_out = r_rd_out;

endmodule

`default_nettype wire
